// File: rtl/alarm_scan_controller.sv
// Alarm scan controller: one shared comparator walks the enabled alarm slots
// on each minute update, then sequences ring / snooze / auto-off.
module alarm_scan_controller #(
    parameter int TIME_W      = 13,
    parameter int NUM_ALARMS  = 7,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  minute_tick,
    input  logic                  sec_tick,
    input  logic [TIME_W-1:0]     CT,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    output logic [2:0]            slot_sel,
    input  logic [TIME_W-1:0]     slot_time,
    input  logic                  stop,
    input  logic                  snooze,
    output logic                  AA,
    output logic [2:0]            active_slot,
    output logic                  scan_busy
);

    localparam int RW = $clog2(RING_SECS + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);

    localparam logic [RW-1:0] RING_INIT = RW'(RING_SECS);
    localparam logic [SW-1:0] SNZ_INIT  = SW'(SNOOZE_SECS);
    localparam logic [RW-1:0] R_ONE     = RW'(1);
    localparam logic [SW-1:0] S_ONE     = SW'(1);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_ALARMS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RING,
        S_SNOOZE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nxt;
    logic [2:0]      r_active;
    logic [2:0]      w_active_nxt;
    logic [RW-1:0]   r_ring_cnt;
    logic [RW-1:0]   w_ring_nxt;
    logic [SW-1:0]   r_snz_cnt;
    logic [SW-1:0]   w_snz_nxt;
    logic            r_aa;
    logic            w_match;
    logic            w_slot_on;
    logic            w_cancel;

    assign w_match   = alarm_en[r_idx] && (slot_time == CT);
    assign w_slot_on = alarm_en[r_active];
    assign w_cancel  = !w_slot_on || stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_active   <= '0;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
            r_aa       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_active   <= w_active_nxt;
            r_ring_cnt <= w_ring_nxt;
            r_snz_cnt  <= w_snz_nxt;
            r_aa       <= (w_state_nxt == S_RING);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_active_nxt = r_active;
        w_ring_nxt   = r_ring_cnt;
        w_snz_nxt    = r_snz_cnt;
        unique case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (minute_tick) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                // a fresh minute restarts the walk against the new CT
                if (minute_tick) begin
                    w_idx_nxt = '0;
                end else if (w_match) begin
                    w_state_nxt  = S_RING;
                    w_active_nxt = r_idx;
                    w_ring_nxt   = RING_INIT;
                    w_idx_nxt    = '0;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            S_RING: begin
                if (w_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (snooze) begin
                    w_state_nxt = S_SNOOZE;
                    w_snz_nxt   = SNZ_INIT;
                end else if (sec_tick) begin
                    if (r_ring_cnt != '0) w_ring_nxt = r_ring_cnt - R_ONE;
                    if (r_ring_cnt == R_ONE) w_state_nxt = S_IDLE;
                end
            end
            S_SNOOZE: begin
                if (w_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (sec_tick) begin
                    if (r_snz_cnt != '0) w_snz_nxt = r_snz_cnt - S_ONE;
                    if (r_snz_cnt == S_ONE) begin
                        w_state_nxt = S_RING;
                        w_ring_nxt  = RING_INIT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        slot_sel    = '0;
        scan_busy   = 1'b0;
        AA          = r_aa;
        active_slot = r_active;
        if (r_state == S_SCAN) begin
            slot_sel  = r_idx;
            scan_busy = 1'b1;
        end
    end

endmodule
